keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Consumer end of the matrix-keypad scanner interface: takes the scanner's held-key code and a key-present flag, then debounces, edge-detects and interprets each press.
- Builds a 4-digit decimal operand (BCD digits plus binary value) for the stopwatch/calculator datapath and the 7-segment display decoders.
- Supports digit entry, backspace, clear and enter.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (minimum 2)
MAX_DIGITS, 4, digit capacity of the entry buffer (fixed at 4 for this revision)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  high while the scanner detects a pressed key
key_code  input  4  scanner key code, meaningful only when key_valid=1
digit3  output  4  BCD thousands digit
digit2  output  4  BCD hundreds digit
digit1  output  4  BCD tens digit
digit0  output  4  BCD units digit
value  output  14  binary value of the current entry, 0..9999
digit_count  output  3  number of digits entered, 0..4
result  output  14  value captured at the last enter
result_valid  output  1  one-cycle pulse when result updates
overflow  output  1  sticky flag: a digit was rejected because the buffer was full

Behaviour:
- Reset (asynchronous, rst_n=0): all digits 0, value 0, digit_count 0, result 0, result_valid 0, overflow 0, FSM in IDLE, debounce counter 0. Takes effect immediately, even mid-debounce or mid-press.
- Key code map: 0x0-0x9 digit; 0xA CLEAR; 0xB BACKSPACE; 0xC ENTER; 0xD-0xF ignored.
- FSM states:
  - IDLE: key_valid=1 -> PRESS_WAIT; sample key_code into cand; clear counter.
  - PRESS_WAIT: each cycle with key_valid=1 and key_code==cand increments counter. key_valid=0 or a code change -> IDLE, counter cleared. Counter reaching DEBOUNCE_CYCLES-1 -> ACCEPT.
  - ACCEPT: one cycle; executes the command for cand; -> HELD.
  - HELD: ignores all codes until key_valid=0 -> RELEASE_WAIT.
  - RELEASE_WAIT: key_valid=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any key_valid=1 -> HELD, counter cleared.
- Press acceptance:
  - Exactly one command per physical press; auto-repeat is not permitted.
  - Acceptance latency: the ACCEPT cycle is DEBOUNCE_CYCLES cycles after the first sampled key_valid=1 cycle. Outputs update on the clock edge that ends ACCEPT.
- Commands:
  - Digit d, digit_count<4: digits shift left (digit3<=digit2, digit2<=digit1, digit1<=digit0, digit0<=d); value<=value*10+d; digit_count+1.
  - Digit d, digit_count==4: no change to digits or value; overflow<=1.
  - BACKSPACE, digit_count>0: digits shift right (digit0<=digit1 ... digit3<=0); value<=value/10; digit_count-1; overflow<=0.
  - BACKSPACE, digit_count==0: no effect.
  - CLEAR: digits, value, digit_count and overflow go to 0; result is untouched.
  - ENTER: result<=value; result_valid=1 for exactly that one cycle; entry buffer cleared as for CLEAR. ENTER with an empty buffer still pulses result_valid and sets result=0.
- Arithmetic and output timing:
  - value*10+d is computed at 14-bit width and never exceeds 9999.
  - value and the digits are always mutually consistent and registered in the same edge.
  - result_valid is 0 in every cycle other than the cycle following an ENTER accept.

Test Plan:
- DEBOUNCE_CYCLES=4. Press '1','2','3' (each held 10 cycles, released 10) -> digits 0,1,2,3; value=123; digit_count=3.
- key_valid pulses of 2 cycles, and a code changing 5->6 at cycle 2 of a hold -> no command is accepted. A 6 held steady afterwards is accepted once.
- Enter 9,8,7,6, then press 5 -> value stays 9876, overflow=1. BACKSPACE -> value=987, overflow=0, digits 0,9,8,7.
- Enter 4,2, then ENTER -> result=42 with a single-cycle result_valid; value=0 and digit_count=0 on the next cycle.
- Hold '7' for 100 cycles -> exactly one digit is accepted. A release bounce of 2 cycles low then high stays in HELD, with no second accept.
- Assert rst_n=0 mid-PRESS_WAIT after 3 digits are entered -> all outputs are 0 immediately. A press after release is processed normally.

Source files
------------

// File: rtl/keypad_entry.sv
// Keypad entry front end: debounces the scanner's held key, accepts one command
// per press, and maintains a 4-digit BCD/binary operand plus an ENTER result.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_DIGITS      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic [13:0] value,
  output logic [2:0]  digit_count,
  output logic [13:0] result,
  output logic        result_valid,
  output logic        overflow
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Press needs DEBOUNCE_CYCLES-1 matches after the sampling cycle; release needs DEBOUNCE_CYCLES lows.
  localparam logic [CW-1:0] CNT_ACC = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_REL = CW'(DEBOUNCE_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESS  = 3'd1;
  localparam logic [2:0] S_ACCEPT = 3'd2;
  localparam logic [2:0] S_HELD   = 3'd3;
  localparam logic [2:0] S_REL    = 3'd4;

  localparam logic [3:0] K_CLEAR = 4'hA;
  localparam logic [3:0] K_BKSP  = 4'hB;
  localparam logic [3:0] K_ENTER = 4'hC;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;
  logic             accept;
  logic [3:0][3:0]  digits_q, digits_d;
  logic [13:0]      value_q, value_d;
  logic [2:0]       count_q, count_d;
  logic [13:0]      result_q, result_d;
  logic             rv_q, rv_d;
  logic             ovf_q, ovf_d;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (key_valid) begin
        state_d = S_PRESS;
        cand_d  = key_code;
        cnt_d   = '0;
      end
      S_PRESS: begin
        if (!key_valid || key_code != cand_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_ACC) begin
          state_d = S_ACCEPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ACCEPT: begin
        accept  = 1'b1;
        state_d = S_HELD;
      end
      S_HELD: if (!key_valid) begin
        state_d = S_REL;
        cnt_d   = '0;
      end
      S_REL: begin
        if (key_valid) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_REL) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    digits_d = digits_q;
    value_d  = value_q;
    count_d  = count_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    rv_d     = 1'b0;
    if (accept) begin
      if (cand_q <= 4'd9) begin
        if (count_q < 3'(MAX_DIGITS)) begin
          digits_d = {digits_q[2:0], cand_q};
          // value <= 999 here, so the 14-bit result stays within 9999
          value_d  = value_q * 14'd10 + {10'd0, cand_q};
          count_d  = count_q + 3'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (cand_q == K_BKSP) begin
        if (count_q != 3'd0) begin
          digits_d = {4'd0, digits_q[3:1]};
          value_d  = value_q / 14'd10;
          count_d  = count_q - 3'd1;
          ovf_d    = 1'b0;
        end
      end else if (cand_q == K_CLEAR || cand_q == K_ENTER) begin
        digits_d = '0;
        value_d  = '0;
        count_d  = '0;
        ovf_d    = 1'b0;
        if (cand_q == K_ENTER) begin
          result_d = value_q;
          rv_d     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      digits_q <= '0;
      value_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      digits_q <= digits_d;
      value_q  <= value_d;
      count_q  <= count_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign digit3       = digits_q[3];
  assign digit2       = digits_q[2];
  assign digit1       = digits_q[1];
  assign digit0       = digits_q[0];
  assign value        = value_q;
  assign digit_count  = count_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with DEBOUNCE_CYCLES=4: vector table of presses
// plus hand-written sequences for bounce, latency, long hold and async reset.
module tb_keypad_entry;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  digit3, digit2, digit1, digit0;
  logic [13:0] value, result;
  logic [2:0]  digit_count;
  logic        result_valid, overflow;

  int checks = 0;
  int errors = 0;
  int rv_seen = 0;

  keypad_entry #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .value(value), .digit_count(digit_count), .result(result),
    .result_valid(result_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid) rv_seen++;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] digs;
    logic [13:0] val;
    logic [2:0]  cnt;
    logic        ovf;
    logic [13:0] res;
    int          rv;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] digs, input logic [13:0] val,
                             input logic [2:0] cnt, input logic ovf, input logic [13:0] res, input int rv);
    check({tag, " digits"}, {16'd0, digit3, digit2, digit1, digit0}, {16'd0, digs});
    check({tag, " value"}, {18'd0, value}, {18'd0, val});
    check({tag, " count"}, {29'd0, digit_count}, {29'd0, cnt});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, ovf});
    check({tag, " result"}, {18'd0, result}, {18'd0, res});
    check({tag, " rv_pulses"}, rv_seen, rv);
  endtask

  task automatic drive(input logic kv, input logic [3:0] code, input int edges);
    key_valid = kv;
    key_code  = code;
    repeat (edges) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    drive(1'b1, code, hold);
    drive(1'b0, 4'h0, rel);
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    tbl[0]  = '{4'h1, 16'h0001, 14'd1,    3'd1, 1'b0, 14'd0,  0};
    tbl[1]  = '{4'h2, 16'h0012, 14'd12,   3'd2, 1'b0, 14'd0,  0};
    tbl[2]  = '{4'h3, 16'h0123, 14'd123,  3'd3, 1'b0, 14'd0,  0};
    tbl[3]  = '{4'hA, 16'h0000, 14'd0,    3'd0, 1'b0, 14'd0,  0};
    tbl[4]  = '{4'h9, 16'h0009, 14'd9,    3'd1, 1'b0, 14'd0,  0};
    tbl[5]  = '{4'h8, 16'h0098, 14'd98,   3'd2, 1'b0, 14'd0,  0};
    tbl[6]  = '{4'h7, 16'h0987, 14'd987,  3'd3, 1'b0, 14'd0,  0};
    tbl[7]  = '{4'h6, 16'h9876, 14'd9876, 3'd4, 1'b0, 14'd0,  0};
    tbl[8]  = '{4'h5, 16'h9876, 14'd9876, 3'd4, 1'b1, 14'd0,  0};
    tbl[9]  = '{4'hB, 16'h0987, 14'd987,  3'd3, 1'b0, 14'd0,  0};
    tbl[10] = '{4'hA, 16'h0000, 14'd0,    3'd0, 1'b0, 14'd0,  0};
    tbl[11] = '{4'h4, 16'h0004, 14'd4,    3'd1, 1'b0, 14'd0,  0};
    tbl[12] = '{4'h2, 16'h0042, 14'd42,   3'd2, 1'b0, 14'd0,  0};
    tbl[13] = '{4'hC, 16'h0000, 14'd0,    3'd0, 1'b0, 14'd42, 1};
    tbl[14] = '{4'hE, 16'h0000, 14'd0,    3'd0, 1'b0, 14'd42, 1};
    tbl[15] = '{4'hB, 16'h0000, 14'd0,    3'd0, 1'b0, 14'd42, 1};
    tbl[16] = '{4'hC, 16'h0000, 14'd0,    3'd0, 1'b0, 14'd0,  2};

    repeat (3) @(posedge clk);
    #1;
    check_state("reset", 16'h0000, 14'd0, 3'd0, 1'b0, 14'd0, 0);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 2);

    for (int i = 0; i < 17; i++) begin
      press(tbl[i].code, 10, 10);
      check_state($sformatf("vec%0d", i), tbl[i].digs, tbl[i].val, tbl[i].cnt,
                  tbl[i].ovf, tbl[i].res, tbl[i].rv);
    end

    // Short pulses and a mid-hold code change must not be accepted
    for (int i = 0; i < 3; i++) press(4'h5, 2, 3);
    press(4'h5, 3, 5);
    drive(1'b1, 4'h5, 2);
    drive(1'b1, 4'h6, 2);
    drive(1'b0, 4'h0, 6);
    check("glitch value", {18'd0, value}, 32'd0);
    check("glitch count", {29'd0, digit_count}, 32'd0);
    press(4'h6, 10, 10);
    check("steady6 value", {18'd0, value}, 32'd6);
    press(4'h1, 4, 10);
    check("min_hold value", {18'd0, value}, 32'd61);

    // Accept lands on the fifth edge after key_valid rises
    drive(1'b1, 4'h2, 4);
    check("latency before", {18'd0, value}, 32'd61);
    drive(1'b1, 4'h2, 1);
    check("latency at", {18'd0, value}, 32'd612);
    drive(1'b1, 4'h2, 5);
    drive(1'b0, 4'h0, 10);
    check("latency count", {29'd0, digit_count}, 32'd3);

    // Long hold then release bounce: a single digit only
    press(4'hA, 10, 10);
    drive(1'b1, 4'h7, 100);
    drive(1'b0, 4'h0, 2);
    drive(1'b1, 4'h7, 10);
    drive(1'b0, 4'h0, 10);
    check("hold7 value", {18'd0, value}, 32'd7);
    check("hold7 count", {29'd0, digit_count}, 32'd1);
    check("hold7 digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0007);

    // Async reset in the middle of a press
    press(4'hA, 10, 10);
    press(4'h1, 10, 10); press(4'h2, 10, 10); press(4'h3, 10, 10);
    press(4'hC, 10, 10);
    check("enter123 result", {18'd0, result}, 32'd123);
    check("enter123 pulses", rv_seen, 32'd3);
    press(4'h1, 10, 10); press(4'h2, 10, 10); press(4'h3, 10, 10);
    drive(1'b1, 4'h4, 2);
    #2;
    rst_n = 1'b0;
    key_valid = 1'b0;
    #1;
    check_state("async_rst", 16'h0000, 14'd0, 3'd0, 1'b0, 14'd0, 3);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 4'h0, 3);
    press(4'h5, 10, 10);
    check_state("post_rst", 16'h0005, 14'd5, 3'd1, 1'b0, 14'd0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
